// File: rtl/alu_acc_ctrl.sv
// Accumulator front-end for the 6-bit ALU: one command in, one result out; load = 1 cycle to result, ALU op = 2.
// Backpressure: result held stable in RESP until out_ready; no command accepted until then.
module alu_acc_ctrl #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_operand,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             sticky_err,
  input  logic             clr_err,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, operand_q;
  logic [2:0]       op_q;
  logic             err_q;
  logic             cmd_fire, out_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    out_valid = 1'b0;
    cmd_fire  = 1'b0;
    out_fire  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_fire  = 1'b1;
          state_nxt = cmd_load ? RESP : EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          out_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The wrapped ALU result is kept even on overflow; err_q only reports it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      op_q      <= '0;
      operand_q <= '0;
      err_q     <= 1'b0;
    end else if (cmd_fire) begin
      op_q      <= cmd_op;
      operand_q <= cmd_operand;
      if (cmd_load) begin
        acc   <= cmd_operand;
        err_q <= 1'b0;
      end
    end else if (state == EXEC) begin
      acc   <= alu_res;
      err_q <= alu_err;
    end
  end

  // A new overflow in the same cycle as clr_err must not be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        sticky_err <= 1'b0;
    else if (state == EXEC && alu_err) sticky_err <= 1'b1;
    else if (clr_err)                  sticky_err <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          op_count <= '0;
    else if (out_fire && op_count != '1) op_count <= op_count + 1'b1;
  end

  assign alu_a    = acc;
  assign alu_b    = operand_q;
  assign alu_op   = op_q;
  assign out_data = acc;
  assign out_err  = err_q;

endmodule

// File: tb/tb_alu_acc_ctrl.sv
// Bench for alu_acc_ctrl with a behavioural 6-bit ALU attached to its ALU port.
// Expected results are queued when a command is driven and popped when out_valid rises.
module tb_alu_acc_ctrl;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_load = 1'b0;
  logic [2:0]   cmd_op = '0;
  logic [W-1:0] cmd_operand = '0;
  logic [W-1:0] alu_a, alu_b, alu_res;
  logic [2:0]   alu_op;
  logic         alu_err;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_err;
  logic         sticky_err;
  logic         clr_err = 1'b0;
  logic [7:0]   op_count;

  int           tests = 0;
  int           fails = 0;
  logic [W:0]   sb[$];
  logic [W-1:0] m_acc = '0;
  logic         m_sticky = 1'b0;
  int           m_count = 0;

  always #5 clk = ~clk;

  alu_acc_ctrl #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_err(alu_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .sticky_err(sticky_err), .clr_err(clr_err),
    .op_count(op_count)
  );

  // Returns {overflow, result}; overflow is signed overflow for ops 0-3.
  function automatic logic [W:0] alu_f(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic         e;
    e = 1'b0;
    case (op)
      3'd0: begin r = a + b; e = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      3'd1: begin r = a - b; e = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      3'd2: begin r = a - 1'b1; e = (a == {1'b1, {(W-1){1'b0}}}); end
      3'd3: begin r = a + 1'b1; e = (a == {1'b0, {(W-1){1'b1}}}); end
      3'd4: r = ~a;
      3'd5: r = a & b;
      3'd6: r = a | b;
      default: r = a ^ b;
    endcase
    return {e, r};
  endfunction

  always_comb {alu_err, alu_res} = alu_f(alu_op, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full command/response; hold = cycles of out_ready low with cmd_valid pushed at the block.
  task automatic do_cmd(input logic ld, input logic [2:0] op, input logic [W-1:0] opd, input int hold);
    logic [W:0] exp;
    logic [W:0] got;
    int         lat;
    @(negedge clk);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid   = 1'b1;
    cmd_load    = ld;
    cmd_op      = op;
    cmd_operand = opd;
    exp = ld ? {1'b0, opd} : alu_f(op, m_acc, opd);
    sb.push_back(exp);
    m_acc = exp[W-1:0];
    if (exp[W]) m_sticky = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), ld ? 32'd1 : 32'd2);
    got = sb.pop_front();
    check("out_data", 32'(out_data), 32'(got[W-1:0]));
    check("out_err", 32'(out_err), 32'(got[W]));
    check("sticky_err", 32'(sticky_err), 32'(m_sticky));
    for (int i = 0; i < hold; i++) begin
      cmd_valid   = 1'b1;
      cmd_load    = 1'b1;
      cmd_operand = ~opd;
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'(got[W-1:0]));
      check("bp_out_err", 32'(out_err), 32'(got[W]));
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp_acc", 32'(alu_a), 32'(m_acc));
    end
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (m_count < 255) m_count++;
    check("op_count", 32'(op_count), 32'(m_count));
    check("out_valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    // 1. reset state, then reset during EXEC
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_acc", 32'(alu_a), 32'd0);
    rst_n = 1'b1;
    do_cmd(1'b1, 3'd0, 6'd9, 0);
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_load    = 1'b0;
    cmd_op      = 3'd0;
    cmd_operand = 6'd10;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    check("exec_operand", 32'(alu_b), 32'd10);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_acc", 32'(alu_a), 32'd0);
    check("arst_operand", 32'(alu_b), 32'd0);
    check("arst_op_count", 32'(op_count), 32'd0);
    check("arst_sticky", 32'(sticky_err), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    m_acc    = '0;
    m_count  = 0;
    m_sticky = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_ready", 32'(cmd_ready), 32'd1);
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end

    // 2. load then add
    do_cmd(1'b1, 3'd0, 6'b001001, 0);
    do_cmd(1'b0, 3'd0, 6'b001010, 0);
    check("add_result_19", 32'(out_data), 32'd19);
    check("op_count_2", 32'(op_count), 32'd2);

    // 3. overflow, sticky, clear
    do_cmd(1'b1, 3'd0, 6'b010000, 0);
    do_cmd(1'b0, 3'd0, 6'b010111, 0);
    check("ovf_add_data", 32'(out_data), 32'b100111);
    check("ovf_sticky", 32'(sticky_err), 32'd1);
    do_cmd(1'b1, 3'd0, 6'b000001, 0);
    do_cmd(1'b0, 3'd3, 6'b000000, 0);
    check("inc_data", 32'(out_data), 32'b000010);
    check("sticky_held", 32'(sticky_err), 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err  = 1'b0;
    m_sticky = 1'b0;
    check("sticky_clr", 32'(sticky_err), 32'd0);

    // 4. backpressure
    do_cmd(1'b1, 3'd0, 6'b000101, 5);
    do_cmd(1'b0, 3'd1, 6'b000010, 5);
    check("bp_sub_data", 32'(out_data), 32'd3);

    // 5. logic chain
    do_cmd(1'b1, 3'd0, 6'b000111, 0);
    do_cmd(1'b0, 3'd7, 6'b111111, 0);
    check("xor_data", 32'(out_data), 32'b111000);
    do_cmd(1'b0, 3'd4, 6'b101010, 0);
    check("not_data", 32'(out_data), 32'b000111);
    do_cmd(1'b0, 3'd5, 6'b000000, 0);
    check("and_data", 32'(out_data), 32'b000000);
    do_cmd(1'b0, 3'd6, 6'b000111, 0);
    check("or_data", 32'(out_data), 32'b000111);

    // 6. boundaries
    do_cmd(1'b1, 3'd0, 6'b100000, 0);
    do_cmd(1'b0, 3'd2, 6'b000000, 0);
    check("dec_min_data", 32'(out_data), 32'b011111);
    check("dec_min_err", 32'(out_err), 32'd1);
    do_cmd(1'b1, 3'd0, 6'b111111, 0);
    do_cmd(1'b0, 3'd3, 6'b000000, 0);
    check("inc_wrap_data", 32'(out_data), 32'b000000);
    check("inc_wrap_err", 32'(out_err), 32'd0);
    for (int i = 0; i < 300; i++) do_cmd(1'b1, 3'd0, 6'(i), 0);
    check("op_count_sat", 32'(op_count), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_acc_ctrl.md
Name: alu_acc_ctrl

Overview:
- Sequential front-end that sits directly upstream of the team's 6-bit ALU (module ALU, ports a, b, op, res, err).
- Accepts commands over a valid/ready handshake and holds a WIDTH-bit accumulator. It drives the ALU operands and opcode, captures the ALU result into the accumulator, and presents each result downstream over a second valid/ready handshake.
- Maintains a sticky overflow flag and a saturating count of executed commands.

Parameters:
WIDTH, 6, datapath width; must match the ALU width.
CNT_W, 8, width of the op_count saturating counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_load  in  1  1 = load cmd_operand into acc (no ALU op); 0 = ALU op
cmd_op  in  3  ALU opcode: 0 add, 1 sub, 2 dec, 3 inc, 4 not, 5 and, 6 or, 7 xor
cmd_operand  in  WIDTH  operand b, or load value
alu_a  out  WIDTH  to ALU a
alu_b  out  WIDTH  to ALU b
alu_op  out  3  to ALU op
alu_res  in  WIDTH  from ALU res (combinational)
alu_err  in  1  from ALU err (two's-complement overflow on ops 0-3; 0 on ops 4-7)
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_data  out  WIDTH  accumulator value after the command
out_err  out  1  overflow flag of this command (0 for load)
sticky_err  out  1  OR of all out_err since reset/clear
clr_err  in  1  synchronous clear of sticky_err
op_count  out  CNT_W  completed commands, saturating

Behaviour:
- Reset (rst_n low, asynchronous, any state including mid-EXEC or RESP):
  - state = IDLE.
  - acc, op_q, operand_q, err_q, sticky_err, op_count all 0.
  - out_valid = 0; cmd_ready is 1 once reset releases.
- alu_a = acc, alu_b = operand_q and alu_op = op_q, all driven directly from registers, so the ALU inputs are glitch-free during EXEC.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch op_q <= cmd_op and operand_q <= cmd_operand.
  - If cmd_load: acc <= cmd_operand, err_q <= 0, go to RESP.
  - Otherwise go to EXEC.
- EXEC (exactly 1 cycle):
  - cmd_ready = 0.
  - At the clock edge: acc <= alu_res, err_q <= alu_err, go to RESP.
- RESP:
  - cmd_ready = 0, out_valid = 1, out_data = acc, out_err = err_q.
  - All outputs are held stable while out_ready = 0.
  - On out_ready: go to IDLE, and increment op_count unless it equals all-ones.
- Latency, counting the command handshake cycle as N:
  - ALU command: out_valid high at N+2.
  - Load: out_valid high at N+1.
  - Minimum command spacing is 3 cycles for an ALU command and 2 cycles for a load.
- Overflow handling:
  - acc takes the wrapped WIDTH-bit ALU result even when alu_err = 1.
  - No saturation is applied.
- sticky_err:
  - Set on the EXEC edge when alu_err = 1.
  - clr_err clears it synchronously.
  - If clr_err coincides with a set, the set wins.
- cmd_valid is ignored outside IDLE, and no command is lost or queued.
- op_count updates only on the RESP handshake.
- Unused operand: for dec, inc and not, operand_q is still latched and driven on alu_b; the ALU ignores it.

Test Plan:
1. Reset mid-operation: load 9, then issue add 10 and pull rst_n low during EXEC -> out_valid, acc, op_count and sticky_err go to 0 immediately, without waiting for a clock edge. After release, cmd_ready = 1 and no stale result appears.
2. Load 001001, then add 001010 with out_ready = 1 -> out_valid at N+2 with out_data = 010011 (19), out_err = 0; op_count = 2.
3. Overflow, sticky flag and clear:
   - Load 010000, then add 010111 -> out_data = 100111, out_err = 1, sticky_err = 1.
   - Load 000001, then inc -> out_data = 000010, out_err = 0, sticky_err stays 1.
   - Pulse clr_err -> sticky_err = 0.
4. Backpressure: hold out_ready = 0 for 5 cycles in RESP while cmd_valid = 1 -> out_valid, out_data and out_err are stable, cmd_ready = 0 and acc is unchanged. Raising out_ready completes the handshake and returns the block to IDLE.
5. Logic chain:
   - Load 000111, then xor 111111 -> 111000 (out_err = 0).
   - Then not -> 000111.
   - Then and 000000 -> 000000.
   - Then or 000111 -> 000111.
6. Boundaries:
   - Load 100000, then dec -> 011111 with out_err = 1.
   - Load 111111, then inc -> 000000 with out_err = 0.
   - Issue 300 commands -> op_count saturates at 255 and holds.
